// File: rtl/mem_access_stage.sv
// Purpose: MEM pipeline stage; issues data-memory loads/stores and produces the MEM/WB register.
// Latency: non-memory ops 1 cycle; memory ops 1 + bus handshake + read response cycles.
// Backpressure: stalls upstream while an access is outstanding; waits on dmem_ready/dmem_rvalid, aborts after TIMEOUT_CYCLES.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              EX_MEM_enable_out,
    input  logic [31:0]       EX_MEM_PC,
    input  logic [31:0]       EX_MEM_ALUResult,
    input  logic [31:0]       EX_MEM_WriteData,
    input  logic [4:0]        EX_MEM_Rd,
    input  logic              EX_MEM_RegWrite,
    input  logic              EX_MEM_MemRead,
    input  logic              EX_MEM_MemWrite,
    input  logic [2:0]        EX_MEM_Funct3,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_wstrb,
    input  logic              dmem_ready,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata,
    output logic              mem_stall,
    output logic              mem_fault,
    output logic [31:0]       MEM_WB_PC,
    output logic [31:0]       MEM_WB_ALUResult,
    output logic [31:0]       MEM_WB_ReadData,
    output logic [4:0]        MEM_WB_Rd,
    output logic              MEM_WB_RegWrite,
    output logic              MEM_WB_MemToReg,
    output logic              MEM_WB_enable_out
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    // Counter only needs to reach TIMEOUT_CYCLES-1: the abort fires on the last allowed cycle.
    localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state;
    logic [TMO_W-1:0] tmo_cnt;

    // Latched copy of the accepted memory op; authoritative while not IDLE.
    logic [31:0]      lat_pc;
    logic [31:0]      lat_alu;
    logic [31:0]      lat_wdata;
    logic [3:0]       lat_wstrb;
    logic [4:0]       lat_rd;
    logic             lat_regwrite;
    logic [2:0]       lat_funct3;
    logic             lat_store;

    logic             is_mem_op;
    logic             size_bad;
    logic             align_bad;
    logic             accept_mem;
    logic             accept_ok;
    logic             accept_fault;
    logic [31:0]      st_wdata;
    logic [3:0]       st_wstrb;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_data;
    logic             st_done;
    logic             ld_done;
    logic             tmo_hit;

    assign is_mem_op = EX_MEM_MemRead | EX_MEM_MemWrite;

    // Legality of the incoming access: encoding first, then natural alignment.
    always_comb begin
        size_bad  = (EX_MEM_Funct3[1:0] == 2'b11)
                  | (EX_MEM_Funct3[2] & EX_MEM_Funct3[1])
                  | (EX_MEM_Funct3[2] & EX_MEM_MemWrite);
        align_bad = ((EX_MEM_Funct3[1:0] == 2'b01) & EX_MEM_ALUResult[0])
                  | ((EX_MEM_Funct3[1:0] == 2'b10) & (|EX_MEM_ALUResult[1:0]));
    end

    assign accept_mem   = (state == IDLE) & EX_MEM_enable_out & is_mem_op;
    assign accept_ok    = accept_mem & ~size_bad & ~align_bad;
    assign accept_fault = accept_mem & (size_bad | align_bad);

    // Store lane placement: data replicated across lanes, strobes select the addressed bytes.
    always_comb begin
        st_wdata = EX_MEM_WriteData;
        st_wstrb = 4'b1111;
        case (EX_MEM_Funct3[1:0])
            2'b00: begin
                st_wdata = {4{EX_MEM_WriteData[7:0]}};
                st_wstrb = 4'b0001 << EX_MEM_ALUResult[1:0];
            end
            2'b01: begin
                st_wdata = {2{EX_MEM_WriteData[15:0]}};
                st_wstrb = 4'b0011 << EX_MEM_ALUResult[1:0];
            end
            default: begin
                st_wdata = EX_MEM_WriteData;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    // Load lane extraction and sign/zero extension from the latched address and size.
    always_comb begin
        case (lat_alu[1:0])
            2'b00:   ld_byte = dmem_rdata[7:0];
            2'b01:   ld_byte = dmem_rdata[15:8];
            2'b10:   ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = lat_alu[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (lat_funct3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = dmem_rdata;
        endcase
    end

    // A load may finish in REQ when the response arrives together with the accept.
    assign st_done = (state == REQ) & dmem_ready & lat_store;
    assign ld_done = ((state == REQ) & dmem_ready & ~lat_store & dmem_rvalid)
                   | ((state == WAIT) & dmem_rvalid);
    assign tmo_hit = TMO_EN & (state != IDLE) & (tmo_cnt == TMO_LAST) & ~st_done & ~ld_done;

    // Access FSM: IDLE -> REQ -> (WAIT) -> IDLE, with timeout abort from REQ/WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_ok) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (tmo_hit || st_done || ld_done) begin
                        state <= IDLE;
                    end else if (dmem_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (tmo_hit || ld_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Timeout counter: cleared on entry to REQ, counts every cycle spent in REQ/WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (accept_ok) begin
            tmo_cnt <= '0;
        end else if (state != IDLE) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Capture the accepted memory op so the bus fields stay stable while upstream is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_pc       <= '0;
            lat_alu      <= '0;
            lat_wdata    <= '0;
            lat_wstrb    <= '0;
            lat_rd       <= '0;
            lat_regwrite <= 1'b0;
            lat_funct3   <= '0;
            lat_store    <= 1'b0;
        end else if (accept_ok) begin
            lat_pc       <= EX_MEM_PC;
            lat_alu      <= EX_MEM_ALUResult;
            lat_wdata    <= EX_MEM_MemWrite ? st_wdata : 32'd0;
            lat_wstrb    <= EX_MEM_MemWrite ? st_wstrb : 4'd0;
            lat_rd       <= EX_MEM_Rd;
            lat_regwrite <= EX_MEM_RegWrite;
            lat_funct3   <= EX_MEM_Funct3;
            lat_store    <= EX_MEM_MemWrite;
        end
    end

    // Fault is a single-cycle pulse for an illegal access or a timeout abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_fault <= 1'b0;
        end else begin
            mem_fault <= accept_fault | tmo_hit;
        end
    end

    // MEM/WB register: bubble by default, loaded on pass-through or access completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            MEM_WB_PC         <= '0;
            MEM_WB_ALUResult  <= '0;
            MEM_WB_ReadData   <= '0;
            MEM_WB_Rd         <= '0;
            MEM_WB_RegWrite   <= 1'b0;
            MEM_WB_MemToReg   <= 1'b0;
            MEM_WB_enable_out <= 1'b0;
        end else begin
            MEM_WB_enable_out <= 1'b0;
            MEM_WB_RegWrite   <= 1'b0;
            if ((state == IDLE) && EX_MEM_enable_out && !is_mem_op) begin
                MEM_WB_PC         <= EX_MEM_PC;
                MEM_WB_ALUResult  <= EX_MEM_ALUResult;
                MEM_WB_ReadData   <= 32'd0;
                MEM_WB_Rd         <= EX_MEM_Rd;
                MEM_WB_RegWrite   <= EX_MEM_RegWrite;
                MEM_WB_MemToReg   <= 1'b0;
                MEM_WB_enable_out <= 1'b1;
            end else if (st_done) begin
                MEM_WB_PC         <= lat_pc;
                MEM_WB_ALUResult  <= lat_alu;
                MEM_WB_ReadData   <= 32'd0;
                MEM_WB_Rd         <= lat_rd;
                MEM_WB_MemToReg   <= 1'b0;
                MEM_WB_enable_out <= 1'b1;
            end else if (ld_done) begin
                MEM_WB_PC         <= lat_pc;
                MEM_WB_ALUResult  <= lat_alu;
                MEM_WB_ReadData   <= ld_data;
                MEM_WB_Rd         <= lat_rd;
                MEM_WB_RegWrite   <= lat_regwrite;
                MEM_WB_MemToReg   <= 1'b1;
                MEM_WB_enable_out <= 1'b1;
            end
        end
    end

    // Bus request is decoded from state so an async reset drops it immediately.
    assign dmem_req   = (state == REQ);
    assign dmem_we    = dmem_req & lat_store;
    assign dmem_addr  = {lat_alu[ADDR_W-1:2], 2'b00};
    assign dmem_wdata = lat_wdata;
    assign dmem_wstrb = lat_wstrb;
    assign mem_stall  = (state != IDLE) | accept_ok;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized scoreboard bench for mem_access_stage with a behavioural reference model.
// Driver plays both upstream pipeline and data-memory responder; monitor checks MEM/WB output.
// Response latencies kept within the timeout window except for the dedicated abort case.
module tb_mem_access_stage;

    localparam int TMO = 4;
    localparam int AW  = 16;

    logic          clk;
    logic          reset;
    logic          EX_MEM_enable_out;
    logic [31:0]   EX_MEM_PC;
    logic [31:0]   EX_MEM_ALUResult;
    logic [31:0]   EX_MEM_WriteData;
    logic [4:0]    EX_MEM_Rd;
    logic          EX_MEM_RegWrite;
    logic          EX_MEM_MemRead;
    logic          EX_MEM_MemWrite;
    logic [2:0]    EX_MEM_Funct3;
    logic          dmem_req;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [31:0]   dmem_wdata;
    logic [3:0]    dmem_wstrb;
    logic          dmem_ready;
    logic          dmem_rvalid;
    logic [31:0]   dmem_rdata;
    logic          mem_stall;
    logic          mem_fault;
    logic [31:0]   MEM_WB_PC;
    logic [31:0]   MEM_WB_ALUResult;
    logic [31:0]   MEM_WB_ReadData;
    logic [4:0]    MEM_WB_Rd;
    logic          MEM_WB_RegWrite;
    logic          MEM_WB_MemToReg;
    logic          MEM_WB_enable_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          fault;
        bit          has_rdata;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
    } exp_t;

    exp_t sb[$];

    mem_access_stage #(.TIMEOUT_CYCLES(TMO), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .EX_MEM_enable_out(EX_MEM_enable_out), .EX_MEM_PC(EX_MEM_PC),
        .EX_MEM_ALUResult(EX_MEM_ALUResult), .EX_MEM_WriteData(EX_MEM_WriteData),
        .EX_MEM_Rd(EX_MEM_Rd), .EX_MEM_RegWrite(EX_MEM_RegWrite),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
        .EX_MEM_Funct3(EX_MEM_Funct3),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .mem_fault(mem_fault),
        .MEM_WB_PC(MEM_WB_PC), .MEM_WB_ALUResult(MEM_WB_ALUResult),
        .MEM_WB_ReadData(MEM_WB_ReadData), .MEM_WB_Rd(MEM_WB_Rd),
        .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_MemToReg(MEM_WB_MemToReg),
        .MEM_WB_enable_out(MEM_WB_enable_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},   {31'd0, dmem_req}, 32'd0);
        chk({tag, "_we"},    {31'd0, dmem_we}, 32'd0);
        chk({tag, "_addr"},  {16'd0, dmem_addr}, 32'd0);
        chk({tag, "_wdata"}, dmem_wdata, 32'd0);
        chk({tag, "_wstrb"}, {28'd0, dmem_wstrb}, 32'd0);
        chk({tag, "_stall"}, {31'd0, mem_stall}, 32'd0);
        chk({tag, "_fault"}, {31'd0, mem_fault}, 32'd0);
        chk({tag, "_wb_pc"}, MEM_WB_PC, 32'd0);
        chk({tag, "_wb_alu"}, MEM_WB_ALUResult, 32'd0);
        chk({tag, "_wb_rdata"}, MEM_WB_ReadData, 32'd0);
        chk({tag, "_wb_rd"}, {27'd0, MEM_WB_Rd}, 32'd0);
        chk({tag, "_wb_ctl"}, {29'd0, MEM_WB_RegWrite, MEM_WB_MemToReg, MEM_WB_enable_out}, 32'd0);
    endtask

    // Upstream keeps presenting garbage while stalled; the stage must ignore it.
    task automatic junk_inputs();
        EX_MEM_enable_out = 1'($urandom_range(0, 1));
        EX_MEM_PC         = $urandom;
        EX_MEM_ALUResult  = $urandom;
        EX_MEM_WriteData  = $urandom;
        EX_MEM_Rd         = 5'($urandom);
        EX_MEM_RegWrite   = 1'($urandom);
        EX_MEM_MemRead    = 1'($urandom);
        EX_MEM_MemWrite   = 1'($urandom);
        EX_MEM_Funct3     = 3'($urandom);
    endtask

    task automatic idle_inputs();
        EX_MEM_enable_out = 1'b0;
        EX_MEM_MemRead    = 1'b0;
        EX_MEM_MemWrite   = 1'b0;
    endtask

    // Issue one instruction (called just after a rising edge) and act as memory until it retires.
    // rdly: REQ cycles before dmem_ready; rvdly: cycles from accept to rvalid (0 = same cycle).
    task automatic issue(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                         input logic [2:0] f3, input int rdly, input int rvdly,
                         input logic [31:0] rdata);
        bit          mem;
        bit          st;
        bit          legal;
        int          nbytes;
        exp_t        e;
        logic [31:0] v;
        logic [31:0] exp_wdata;
        logic [31:0] exp_wstrb;
        logic [31:0] exp_addr;
        int          i;
        bit          fin;

        mem    = mr | mw;
        st     = mw;
        nbytes = 1 << f3[1:0];
        legal  = 1;
        if (mem) begin
            if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) legal = 0;
            if (st && f3 >= 3'd4) legal = 0;
            if (legal && (alu % nbytes) != 0) legal = 0;
        end

        // Reference values derived straight from the access rules.
        v = rdata >> (8 * int'(alu[1:0]));
        if (f3[1:0] == 2'd0) begin
            v = v & 32'hFF;
            if (!f3[2] && v >= 32'h80) v = v - 32'h100;
        end else if (f3[1:0] == 2'd1) begin
            v = v & 32'hFFFF;
            if (!f3[2] && v >= 32'h8000) v = v - 32'h10000;
        end
        if (f3[1:0] == 2'd0)      exp_wdata = (wd & 32'hFF) * 32'h0101_0101;
        else if (f3[1:0] == 2'd1) exp_wdata = (wd & 32'hFFFF) * 32'h0001_0001;
        else                      exp_wdata = wd;
        exp_wstrb = ((32'd1 << nbytes) - 1) << alu[1:0];
        exp_addr  = (alu % (32'd1 << AW)) & ~32'd3;

        e.fault     = mem && (!legal || rdly >= TMO);
        e.has_rdata = !st;
        e.pc        = pc;
        e.alu       = alu;
        e.rd        = rd;
        e.rw        = mem ? (st ? 1'b0 : rw) : rw;
        e.m2r       = mem && !st;
        e.rdata     = mem ? v : 32'd0;
        sb.push_back(e);

        EX_MEM_enable_out = 1'b1;
        EX_MEM_PC         = pc;
        EX_MEM_ALUResult  = alu;
        EX_MEM_WriteData  = wd;
        EX_MEM_Rd         = rd;
        EX_MEM_RegWrite   = rw;
        EX_MEM_MemRead    = mr;
        EX_MEM_MemWrite   = mw;
        EX_MEM_Funct3     = f3;
        @(negedge clk);
        chk("accept_stall", {31'd0, mem_stall}, {31'd0, mem && legal});
        chk("accept_noreq", {31'd0, dmem_req}, 32'd0);
        @(posedge clk); #1;
        idle_inputs();

        if (mem && legal) begin
            i   = 0;
            fin = 0;
            while (!fin && i < TMO) begin
                junk_inputs();
                dmem_ready  = (i == rdly);
                dmem_rvalid = !st && (i == rdly) && (rvdly == 0);
                dmem_rdata  = dmem_rvalid ? rdata : $urandom;
                @(negedge clk);
                chk("req_vld",   {31'd0, dmem_req}, 32'd1);
                chk("req_we",    {31'd0, dmem_we}, {31'd0, st});
                chk("req_addr",  {16'd0, dmem_addr}, exp_addr);
                chk("req_stall", {31'd0, mem_stall}, 32'd1);
                if (st) begin
                    chk("req_wdata", dmem_wdata, exp_wdata);
                    chk("req_wstrb", {28'd0, dmem_wstrb}, exp_wstrb);
                end
                @(posedge clk); #1;
                if (i == rdly) begin
                    fin = 1;
                    dmem_ready  = 1'b0;
                    dmem_rvalid = 1'b0;
                    if (!st) begin
                        for (int j = 1; j <= rvdly; j++) begin
                            junk_inputs();
                            dmem_rvalid = (j == rvdly);
                            dmem_rdata  = dmem_rvalid ? rdata : $urandom;
                            @(negedge clk);
                            chk("wait_noreq", {31'd0, dmem_req}, 32'd0);
                            chk("wait_stall", {31'd0, mem_stall}, 32'd1);
                            @(posedge clk); #1;
                        end
                    end
                end
                i++;
            end
            dmem_ready  = 1'b0;
            dmem_rvalid = 1'b0;
            idle_inputs();
        end
    endtask

    // Scoreboard monitor: compares MEM/WB and fault against the next expected retirement.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (!MEM_WB_enable_out) chk("bubble_regwrite", {31'd0, MEM_WB_RegWrite}, 32'd0);
                if (MEM_WB_enable_out || mem_fault) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_output enable=%0d fault=%0d required=no output",
                                 MEM_WB_enable_out, mem_fault);
                    end else begin
                        e = sb.pop_front();
                        chk("out_fault", {31'd0, mem_fault}, {31'd0, e.fault});
                        chk("out_enable", {31'd0, MEM_WB_enable_out}, {31'd0, !e.fault});
                        if (!e.fault) begin
                            chk("wb_pc", MEM_WB_PC, e.pc);
                            chk("wb_alu", MEM_WB_ALUResult, e.alu);
                            chk("wb_rd", {27'd0, MEM_WB_Rd}, {27'd0, e.rd});
                            chk("wb_regwrite", {31'd0, MEM_WB_RegWrite}, {31'd0, e.rw});
                            chk("wb_memtoreg", {31'd0, MEM_WB_MemToReg}, {31'd0, e.m2r});
                            if (e.has_rdata) chk("wb_readdata", MEM_WB_ReadData, e.rdata);
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] addr;
        logic        mr;
        logic        mw;
        int          kind;
        int          rdly;
        int          rvdly;

        reset       = 1'b1;
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'd0;
        EX_MEM_PC = 0; EX_MEM_ALUResult = 0; EX_MEM_WriteData = 0; EX_MEM_Rd = 0;
        EX_MEM_RegWrite = 0; EX_MEM_Funct3 = 0;
        idle_inputs();
        #3;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed cases.
        issue(32'h100, 32'h55, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 3'b000, 0, 0, 32'h0);
        issue(32'h200, 32'h1003, 32'hAB, 5'd7, 1'b1, 1'b0, 1'b1, 3'b000, 1, 0, 32'h0);
        issue(32'h204, 32'h2002, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 3'b000, 0, 1, 32'h0080_0000);
        issue(32'h208, 32'h2002, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 3'b100, 0, 1, 32'h0080_0000);
        issue(32'h20C, 32'h4000, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 3'b010, 0, 0, 32'hDEAD_BEEF);
        issue(32'h210, 32'h3002, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 3'b010, 0, 0, 32'h0);
        issue(32'h214, 32'h6002, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 3'b001, 1, 2, 32'h8001_0000);
        issue(32'h218, 32'h7006, 32'h1234_5678, 5'd13, 1'b0, 1'b1, 1'b1, 3'b001, 3, 0, 32'h0);

        // Timeout: ready never comes; abort after TMO cycles, then a late rvalid is ignored.
        issue(32'h300, 32'h5000, 32'h0, 5'd14, 1'b1, 1'b1, 1'b0, 3'b010, 99, 0, 32'h0);
        @(negedge clk);
        chk("tmo_noreq", {31'd0, dmem_req}, 32'd0);
        chk("tmo_nostall", {31'd0, mem_stall}, 32'd0);
        @(posedge clk); #1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset while a load waits for its response.
        EX_MEM_enable_out = 1'b1; EX_MEM_PC = 32'h400; EX_MEM_ALUResult = 32'h8000;
        EX_MEM_Rd = 5'd15; EX_MEM_RegWrite = 1'b1; EX_MEM_MemRead = 1'b1;
        EX_MEM_MemWrite = 1'b0; EX_MEM_Funct3 = 3'b010;
        @(posedge clk); #1;
        idle_inputs();
        dmem_ready = 1'b1;
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        @(negedge clk);
        chk("wait_state_stall", {31'd0, mem_stall}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("rst_wait");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1111_2222;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        chk("post_rst_noreq", {31'd0, dmem_req}, 32'd0);
        @(posedge clk); #1;

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                chk("idle_stall", {31'd0, mem_stall}, 32'd0);
                @(posedge clk); #1;
            end
            kind = $urandom_range(0, 9);
            mr = (kind >= 3 && kind <= 5) || kind == 9;
            mw = (kind >= 6);
            if ($urandom_range(0, 3) != 0)
                f3 = mw ? 3'($urandom_range(0, 2)) : 3'(3'd0 + 3'($urandom_range(0, 4)) + ($urandom_range(0, 4) >= 3 ? 3'd1 : 3'd0));
            else
                f3 = 3'($urandom);
            addr = $urandom;
            if ($urandom_range(0, 2) != 0) addr[1:0] = addr[1:0] & ~((2'd1 << f3[1:0]) - 2'd1);
            rdly  = $urandom_range(0, 2);
            rvdly = $urandom_range(0, 3 - rdly);
            issue($urandom, addr, $urandom, 5'($urandom), 1'($urandom), mr, mw, f3,
                  rdly, rvdly, $urandom);
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline stage directly downstream of the execute stage. Consumes the EX/MEM register outputs and performs data-memory loads and stores over a valid/ready request bus with a separate read-response channel.
- Produces the MEM/WB pipeline register and stalls the upstream pipeline while an access is outstanding.
- Non-memory instructions pass through with 1-cycle latency.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles in REQ+WAIT before abort with fault; 0 disables the timeout.
- ADDR_W, 32, data-bus address width (addresses truncated to ADDR_W LSBs).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- EX_MEM_enable_out  in  1  valid instruction present in EX/MEM
- EX_MEM_PC  in  32  instruction PC
- EX_MEM_ALUResult  in  32  ALU result / effective address
- EX_MEM_WriteData  in  32  store data (rs2)
- EX_MEM_Rd  in  5  destination register
- EX_MEM_RegWrite  in  1  register write enable
- EX_MEM_MemRead  in  1  load instruction
- EX_MEM_MemWrite  in  1  store instruction
- EX_MEM_Funct3  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = store
- dmem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- dmem_wdata  out  32  lane-shifted store data
- dmem_wstrb  out  4  byte strobes
- dmem_ready  in  1  request accepted this cycle
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load data word
- mem_stall  out  1  stall upstream (to combined_stall)
- mem_fault  out  1  1-cycle pulse: misaligned/illegal access or timeout
- MEM_WB_PC  out  32
- MEM_WB_ALUResult  out  32
- MEM_WB_ReadData  out  32  extended load data
- MEM_WB_Rd  out  5
- MEM_WB_RegWrite  out  1
- MEM_WB_MemToReg  out  1  1 = write back ReadData
- MEM_WB_enable_out  out  1  valid instruction in MEM/WB

Behaviour:
- Reset: all outputs and all internal registers 0; state IDLE; timeout counter 0. Reset asserted mid-access drops dmem_req immediately (async) and discards the access; no response is awaited after reset.
- FSM states: IDLE, REQ, WAIT.
- IDLE, valid non-memory op (MemRead=MemWrite=0): next edge loads MEM_WB_* from inputs, MEM_WB_MemToReg=0, MEM_WB_ReadData=0, MEM_WB_enable_out=1.
- IDLE, no valid input: MEM_WB_enable_out=0 and MEM_WB_RegWrite=0; other MEM_WB_* hold.
- IDLE, valid memory op:
  - Check alignment and funct3. H requires addr[0]=0; W requires addr[1:0]=0. Funct3 011/110/111 is illegal; store with funct3 100/101 is illegal.
  - Fault case: no bus access, mem_fault pulses next cycle, MEM_WB_enable_out=0, RegWrite=0, stay IDLE, mem_stall=0.
  - Legal case: latch PC/addr/data/Rd/RegWrite/funct3/type, mem_stall=1 combinationally this cycle, go to REQ.
  - MemRead and MemWrite both 1 is treated as a store.
- REQ:
  - dmem_req=1 with dmem_addr/we/wdata/wstrb stable until dmem_ready.
  - Store on dmem_ready: next edge MEM_WB_enable_out=1, RegWrite=0, go to IDLE.
  - Load on dmem_ready: go to WAIT. If dmem_rvalid is also high that cycle, complete as in WAIT and go to IDLE.
- WAIT: dmem_req=0. On dmem_rvalid, capture and extend data, next edge MEM_WB_enable_out=1, MemToReg=1, RegWrite=latched value, go to IDLE.
- Load extract uses byte lane addr[1:0] or half lane addr[1]. B/H sign-extend; BU/HU zero-extend; W uses the word as-is.
- Store strobes: B 0001<<addr[1:0], data {4{b}}; H 0011<<addr[1:0], data {2{h}}; W 1111.
- mem_stall = (state≠IDLE) OR (IDLE AND legal memory op accepted). Inputs are ignored while state≠IDLE; the latched copy is authoritative.
- While state≠IDLE and not completing: MEM_WB_enable_out=0, MEM_WB_RegWrite=0 (bubble).
- Timeout: counter clears on entry to REQ and increments each cycle in REQ/WAIT. At TIMEOUT_CYCLES, abort: dmem_req=0, mem_fault pulse, bubble output, go to IDLE. A late dmem_rvalid in IDLE is ignored.
- Each memory op completes exactly once; never more than one outstanding request.

Test Plan:
- Non-memory op: PC=0x100, ALUResult=0x55, Rd=3, RegWrite=1 → next cycle MEM_WB_enable_out=1, ALUResult=0x55, MemToReg=0, mem_stall never high.
- Store SB: addr=0x1003, data=0xAB, dmem_ready after 2 cycles → dmem_wstrb=1000, dmem_wdata=0xABABABAB, dmem_addr=0x1000; mem_stall high 3 cycles, then one MEM_WB_enable_out pulse with RegWrite=0.
- Load LB: addr=0x2002, dmem_rdata=0x0080_0000, rvalid 1 cycle after ready → MEM_WB_ReadData=0xFFFFFF80. Repeat with LBU → 0x00000080.
- Load LW with dmem_ready and dmem_rvalid in the same cycle, rdata=0xDEADBEEF → completes in that cycle, ReadData=0xDEADBEEF, returns to IDLE.
- Misaligned LW at addr=0x3002 → no dmem_req, mem_fault pulses 1 cycle, MEM_WB_enable_out=0.
- TIMEOUT_CYCLES=4, dmem_ready held 0 → abort after 4 cycles with mem_fault=1, dmem_req=0. Separately, assert reset during WAIT → all outputs 0 and state IDLE immediately.
